// File: rtl/gselect_arbiter.sv
// gselect_arbiter
//   Round-robin front end that lets two branch-record requesters share one
//   gselect predictor. Each cycle at most one (pc, taken) record is handed to
//   the predictor as a combined lookup+update. The prediction comes back one
//   cycle later, tagged with the owning requester. Per-requester branch and
//   mispredict counters are kept here because the predictor itself cannot
//   attribute mispredicts to a requester.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   run, clear            global enable, synchronous counter clear
//   reqN_valid/pc/taken   requester N record (held until accepted)
//   reqN_ready            requester N record accepted this cycle
//   bp_valid/pc/taken     predictor strobe and record
//   bp_pred               predictor's combinational prediction
//   rsp_valid/id/pred/mispredict  registered response, one cycle after accept
//   branchesN, mispredN   saturating per-requester statistics

module gselect_arbiter_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;                 // clear beats a coincident increment
        else if (inc && count != '1)
            count <= count + 1'b1;       // saturate, never wrap
    end
endmodule

module gselect_arbiter #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             clear,
    input  logic             req0_valid,
    input  logic [PC_W-1:0]  req0_pc,
    input  logic             req0_taken,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [PC_W-1:0]  req1_pc,
    input  logic             req1_taken,
    output logic             req1_ready,
    output logic             bp_valid,
    output logic [PC_W-1:0]  bp_pc,
    output logic             bp_taken,
    input  logic             bp_pred,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_pred,
    output logic             rsp_mispredict,
    output logic [CNT_W-1:0] branches0,
    output logic [CNT_W-1:0] branches1,
    output logic [CNT_W-1:0] mispred0,
    output logic [CNT_W-1:0] mispred1
);
    localparam int NREQ = 2;

    logic             last_grant;
    logic             grant0, grant1, accept, gid;
    logic             active;
    logic [NREQ-1:0]  inc_br, inc_mp;
    logic [NREQ-1:0][CNT_W-1:0] br_cnt, mp_cnt;

    // reset_n gates the grant so the handshake outputs drop as soon as
    // reset asserts, not just at the next edge.
    assign active = run & reset_n;

    // On a tie, the requester that did not win last time gets the slot.
    assign grant0 = active & req0_valid & (~req1_valid |  last_grant);
    assign grant1 = active & req1_valid & (~req0_valid | ~last_grant);
    assign accept = grant0 | grant1;
    assign gid    = grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        bp_valid = accept;
        bp_pc    = '0;
        bp_taken = 1'b0;
        if (grant0) begin
            bp_pc    = req0_pc;
            bp_taken = req0_taken;
        end else if (grant1) begin
            bp_pc    = req1_pc;
            bp_taken = req1_taken;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_pred       <= 1'b0;
            rsp_mispredict <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                last_grant     <= gid;
                rsp_id         <= gid;
                rsp_pred       <= bp_pred;
                rsp_mispredict <= bp_pred ^ bp_taken;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign inc_br[g] = accept & (gid == g[0]);
        assign inc_mp[g] = inc_br[g] & (bp_pred ^ bp_taken);

        gselect_arbiter_sat_cnt #(.CNT_W(CNT_W)) u_br (
            .clk(clk), .reset_n(reset_n), .clear(clear),
            .inc(inc_br[g]), .count(br_cnt[g])
        );
        gselect_arbiter_sat_cnt #(.CNT_W(CNT_W)) u_mp (
            .clk(clk), .reset_n(reset_n), .clear(clear),
            .inc(inc_mp[g]), .count(mp_cnt[g])
        );
    end

    assign branches0 = br_cnt[0];
    assign branches1 = br_cnt[1];
    assign mispred0  = mp_cnt[0];
    assign mispred1  = mp_cnt[1];
endmodule

// File: tb/tb_gselect_arbiter.sv
module tb_gselect_arbiter;
    localparam int PC_W  = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n, run, clear;
    logic req0_valid, req0_taken, req0_ready;
    logic req1_valid, req1_taken, req1_ready;
    logic [PC_W-1:0] req0_pc, req1_pc, bp_pc;
    logic bp_valid, bp_taken, bp_pred;
    logic rsp_valid, rsp_id, rsp_pred, rsp_mispredict;
    logic [CNT_W-1:0] branches0, branches1, mispred0, mispred1;

    int ncmp = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gselect_arbiter #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear),
        .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_taken(req0_taken),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_taken(req1_taken),
        .req1_ready(req1_ready),
        .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .bp_pred(bp_pred),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pred(rsp_pred),
        .rsp_mispredict(rsp_mispredict),
        .branches0(branches0), .branches1(branches1),
        .mispred0(mispred0), .mispred1(mispred1)
    );

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_last;             // id of previous winner
    int m_rv, m_rid, m_rp, m_rm;
    int m_br[2], m_mp[2];
    int win;                // -1 none, else winning requester

    always_comb begin
        win = -1;
        if (reset_n === 1'b1 && run === 1'b1) begin
            if (req0_valid && req1_valid) win = 1 - m_last;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last <= 1; m_rv <= 0; m_rid <= 0; m_rp <= 0; m_rm <= 0;
            m_br <= '{0, 0}; m_mp <= '{0, 0};
        end else begin
            int tk;
            tk = (win == 1) ? int'(req1_taken) : int'(req0_taken);
            m_rv <= (win >= 0);
            if (win >= 0) begin
                m_last <= win;
                m_rid  <= win;
                m_rp   <= int'(bp_pred);
                m_rm   <= (int'(bp_pred) != tk);
            end
            for (int r = 0; r < 2; r++) begin
                if (clear) begin
                    m_br[r] <= 0;
                    m_mp[r] <= 0;
                end else if (win == r) begin
                    if (m_br[r] < MAXC) m_br[r] <= m_br[r] + 1;
                    if (int'(bp_pred) != tk && m_mp[r] < MAXC) m_mp[r] <= m_mp[r] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready0",   int'(req0_ready), int'(win == 0));
            chk("ready1",   int'(req1_ready), int'(win == 1));
            chk("bp_valid", int'(bp_valid),   int'(win >= 0));
            chk("bp_pc",    int'(bp_pc),
                win == 0 ? int'(req0_pc) : win == 1 ? int'(req1_pc) : 0);
            chk("bp_taken", int'(bp_taken),
                win == 0 ? int'(req0_taken) : win == 1 ? int'(req1_taken) : 0);
            chk("rsp_valid", int'(rsp_valid), m_rv);
            chk("rsp_id",    int'(rsp_id),    m_rid);
            chk("rsp_pred",  int'(rsp_pred),  m_rp);
            chk("rsp_misp",  int'(rsp_mispredict), m_rm);
            chk("branches0", int'(branches0), m_br[0]);
            chk("branches1", int'(branches1), m_br[1]);
            chk("mispred0",  int'(mispred0),  m_mp[0]);
            chk("mispred1",  int'(mispred1),  m_mp[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int gpat[6];
        gpat = '{0, 1, 0, 1, 0, 1};
        reset_n = 0; run = 0; clear = 0; bp_pred = 0;
        req0_valid = 0; req0_pc = '0; req0_taken = 0;
        req1_valid = 0; req1_pc = '0; req1_taken = 0;
        tick(); tick();
        chk_en = 1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_branches0", int'(branches0), 0);
        reset_n = 1;
        tick();

        // requester 0 alone, 4 records
        run = 1; req0_valid = 1; req0_taken = 1;
        for (int i = 0; i < 4; i++) begin
            req0_pc = 8'h10 * (i + 1);
            #1;
            chk("t1_ready0", int'(req0_ready), 1);
            chk("t1_bp_pc", int'(bp_pc), 16 * (i + 1));
            if (i > 0) chk("t1_rsp_id", int'(rsp_id) + 2 * int'(rsp_valid), 2);
            tick();
        end
        req0_valid = 0;
        #1 chk("t1_last_rsp", int'(rsp_valid), 1);
        tick();
        chk("t1_br0", int'(branches0), 4);
        chk("t1_br1", int'(branches1), 0);
        chk("t1_rsp_drop", int'(rsp_valid), 0);

        // fresh start, both requesters contend for 6 cycles
        reset_n = 0; #1; reset_n = 1;
        req0_valid = 1; req1_valid = 1; req0_pc = 8'hA0; req1_pc = 8'hB0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_grant1", int'(req1_ready), gpat[i]);
            if (i > 0) chk("t2_rsp_id", int'(rsp_id), gpat[i-1]);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        #1 chk("t2_rsp_id_last", int'(rsp_id), 1);
        tick();
        chk("t2_br0", int'(branches0), 3);
        chk("t2_br1", int'(branches1), 3);

        // clear while idle, then mispredict attribution on requester 1
        clear = 1; tick(); clear = 0;
        req1_valid = 1; req1_taken = 0;
        for (int i = 0; i < 5; i++) begin
            bp_pred = (i < 3);
            req1_pc = 8'h40 + i[7:0];
            tick();
            chk("t3_misp_pat", int'(rsp_mispredict), int'(i < 3));
        end
        req1_valid = 0; bp_pred = 0;
        tick();
        chk("t3_mp1", int'(mispred1), 3);
        chk("t3_br1", int'(branches1), 5);

        // build branches0 to 7, then clear coincident with an acceptance
        req0_valid = 1; req0_taken = 1;
        for (int i = 0; i < 7; i++) tick();
        req0_valid = 0; tick();
        chk("t4_br0_pre", int'(branches0), 7);
        req0_valid = 1; clear = 1;
        #1 chk("t4_ready0", int'(req0_ready), 1);
        tick();
        clear = 0; req0_valid = 0;
        chk("t4_br0_clr", int'(branches0), 0);
        chk("t4_rsp", int'(rsp_valid), 1);
        tick();

        // run dropped while both requesters wait (last winner was 0)
        req0_valid = 1; req1_valid = 1;
        #1 chk("t5_ready1", int'(req1_ready), 1);
        tick();
        run = 0;
        #1;
        chk("t5_off_r0", int'(req0_ready), 0);
        chk("t5_off_r1", int'(req1_ready), 0);
        chk("t5_off_bp", int'(bp_valid), 0);
        chk("t5_rsp_once", int'(rsp_valid), 1);
        tick();
        chk("t5_rsp_drop", int'(rsp_valid), 0);
        tick();
        run = 1;
        #1 chk("t5_resume_r0", int'(req0_ready), 1);
        tick();
        req0_valid = 0; req1_valid = 0; tick();

        // saturation of the 4-bit counters on requester 1
        clear = 1; tick(); clear = 0;
        req1_valid = 1; req1_taken = 1; bp_pred = 0;
        for (int i = 0; i < MAXC + 2; i++) tick();
        req1_valid = 0; tick();
        chk("t6_br1_sat", int'(branches1), 15);
        chk("t6_mp1_sat", int'(mispred1), 15);

        // reset asserted mid-burst
        req0_valid = 1; req1_valid = 1;
        tick(); tick(); tick();
        #1 reset_n = 0;
        #1;
        chk("t7_r0", int'(req0_ready), 0);
        chk("t7_r1", int'(req1_ready), 0);
        chk("t7_bp", int'(bp_valid), 0);
        chk("t7_rsp", int'(rsp_valid), 0);
        chk("t7_br", int'(branches0) + int'(branches1), 0);
        @(negedge clk); #1;
        reset_n = 1;
        #1;
        chk("t7_first_r0", int'(req0_ready), 1);
        chk("t7_no_rsp", int'(rsp_valid), 0);
        tick();
        chk("t7_rsp_id", int'(rsp_id), 0);
        req0_valid = 0; req1_valid = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
